seg7_bcd_collector: RTL and testbench
=====================================

SEG7_BCD_COLLECTOR -- requirements
Module: seg7_bcd_collector

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of BCD digits collected per output word (legal range 1..8).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 seg_in  input  7  SHALL carry a 7-segment pattern, bit 6 = segment a through bit 0 = segment g, active-high.
REQ-005 in_valid  input  1  SHALL mark seg_in as valid this cycle.
REQ-006 in_ready  output  1  SHALL indicate the block accepts a pattern this cycle.
REQ-007 out_bcd  output  4*DIGITS  SHALL hold the collected digits, most significant digit first received in the top nibble.
REQ-008 out_err  output  1  SHALL flag that the word ended on an illegal pattern.
REQ-009 out_valid  output  1  SHALL indicate out_bcd/out_err are presented.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes the word this cycle.

Function
REQ-011 Decode table SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; blank=0000000; any other value is illegal.
REQ-012 FSM states SHALL be IDLE, COLLECT, DONE, ERROR.
REQ-013 in_ready SHALL be 1 in IDLE and COLLECT, 0 in DONE and ERROR; out_valid SHALL be 1 exactly in DONE and ERROR.
REQ-014 An accepted beat (in_valid & in_ready) with a legal digit SHALL shift out_bcd left 4 bits, load the digit into the low nibble, and increment the digit counter (width clog2(DIGITS+1)).
REQ-015 IDLE SHALL move to COLLECT on the first accepted legal digit; if that digit completes DIGITS it SHALL go straight to DONE.
REQ-016 The accepted digit that brings the count to DIGITS SHALL move the FSM to DONE, with out_valid high on the next cycle (latency 1 cycle from final accept).
REQ-017 An accepted blank pattern SHALL be consumed with no shift, no count change and no state change.
REQ-018 An accepted illegal pattern SHALL move to ERROR, set out_err=1, and leave out_bcd and the counter unchanged.
REQ-019 In DONE or ERROR, out_valid & out_ready SHALL return the FSM to IDLE on the next edge, clearing out_bcd, out_err and the counter; in_ready SHALL be 1 in that following cycle.
REQ-020 out_bcd and out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 in_valid while in_ready=0 SHALL be ignored (no state effect).

Reset
REQ-022 Assertion of reset at any time, including mid-word, SHALL force IDLE, counter=0, out_bcd=0, out_err=0, out_valid=0, in_ready=1 (after reset release) without waiting for a clock edge.
REQ-023 Partially collected digits SHALL be discarded by reset.

Configuration
REQ-024 With macro SEG7_ACTIVE_LOW_EN defined, seg_in SHALL be inverted before decode (common-anode input); without it, seg_in SHALL be decoded as active-high per REQ-011.

Structure
REQ-025 Package seg7_pkg SHALL hold the ten digit pattern constants, the blank constant and the FSM state encoding.
REQ-026 Sub-module seg7_decode SHALL be combinational: seg pattern in -> 4-bit digit, is_blank, is_illegal out; the collector SHALL instantiate it once.

Verification
REQ-027 Reset, then send patterns 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_bcd=16'h1234, out_err=0, then IDLE.
REQ-028 Send 9, blank, 0, blank, 7, 5 -> out_bcd=16'h9075, blanks do not count.
REQ-029 Send 5, 6, then 0000001 -> ERROR, out_valid=1, out_err=1, out_bcd=16'h0056, in_ready=0 until out_ready.
REQ-030 Complete word 8,8,8,8 with out_ready=0 for 5 cycles and in_valid held high -> out_bcd=16'h8888 stable, no pattern accepted; out_ready=1 -> IDLE next edge.
REQ-031 Send 3,1 then assert reset mid-cycle -> outputs zero immediately; after release send 2,0,2,3 -> out_bcd=16'h2023.
REQ-032 With SEG7_ACTIVE_LOW_EN defined, send 0000001,1001111,0010010,0000110 -> out_bcd=16'h0123.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment digit patterns (a..g, bit 6 = a) and collector FSM encoding.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_ERROR   = 2'd3;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 7-segment to BCD decoder with blank/illegal flags.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       is_blank_o,
    output logic       is_illegal_o
);
    // 4'hf marks "not a digit"; blank is told apart by its own flag
    always_comb begin
        digit_o      = seg_i == SEG_0 ? 4'd0 :
                       seg_i == SEG_1 ? 4'd1 :
                       seg_i == SEG_2 ? 4'd2 :
                       seg_i == SEG_3 ? 4'd3 :
                       seg_i == SEG_4 ? 4'd4 :
                       seg_i == SEG_5 ? 4'd5 :
                       seg_i == SEG_6 ? 4'd6 :
                       seg_i == SEG_7 ? 4'd7 :
                       seg_i == SEG_8 ? 4'd8 :
                       seg_i == SEG_9 ? 4'd9 : 4'hf;
        is_blank_o   = seg_i == SEG_BLANK;
        is_illegal_o = digit_o == 4'hf && !is_blank_o;
    end
endmodule

// File: rtl/seg7_bcd_collector.sv
// seg7_bcd_collector: gathers DIGITS decoded 7-segment digits into a BCD word.
// Define SEG7_ACTIVE_LOW_EN for common-anode (active-low) segment inputs.
module seg7_bcd_collector
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [6:0]    seg_dec;
    logic [3:0]    digit;
    logic          is_blank, is_illegal, accept;

`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_dec = ~seg_in;
`else
    assign seg_dec = seg_in;
`endif

    seg7_decode u_decode (
        .seg_i        (seg_dec),
        .digit_o      (digit),
        .is_blank_o   (is_blank),
        .is_illegal_o (is_illegal)
    );

    assign in_ready  = state_q == ST_IDLE || state_q == ST_COLLECT;
    assign out_valid = state_q == ST_DONE || state_q == ST_ERROR;
    assign accept    = in_valid && in_ready;
    assign out_bcd   = bcd_q;
    assign out_err   = err_q;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (out_valid && out_ready) begin
            state_d = ST_IDLE;
            bcd_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (accept && is_illegal) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
        end else if (accept && !is_blank) begin
            bcd_d   = (bcd_q << 4) | BW'(digit);
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(DIGITS - 1) ? ST_DONE : ST_COLLECT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_seg7_bcd_collector.sv
// tb_seg7_bcd_collector: directed checks of the 4-digit 7-segment BCD collector.
module tb_seg7_bcd_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in = 7'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_bcd;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
    int          nchk = 0;
    int          nerr = 0;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                           P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                           P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                           P9 = 7'b1111011, PB = 7'b0000000, PX = 7'b0000001;

    seg7_bcd_collector #(.DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // bench patterns are written active-high; drive the wire polarity the build expects
    function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG7_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [6:0] p);
        @(negedge clk);
        in_valid = 1'b1;
        seg_in   = enc(p);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_bcd"}, 32'(out_bcd), 32'h0);
        chk({tag, "_err"}, 32'(out_err), 32'd0);
    endtask

    initial begin
        #1 chk_idle("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1 chk_idle("rst_rel");

        out_ready = 1'b1;
        send(P1); send(P2); send(P3);
        chk("w1_pre_valid", 32'(out_valid), 32'd0);
        send(P4);
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_bcd", 32'(out_bcd), 32'h1234);
        chk("w1_err", 32'(out_err), 32'd0);
        chk("w1_inrdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_idle("w1_idle");

        send(P9); send(PB); send(P0); send(PB); send(P7);
        chk("w2_pre_valid", 32'(out_valid), 32'd0);
        chk("w2_pre_bcd", 32'(out_bcd), 32'h907);
        send(P5);
        chk("w2_valid", 32'(out_valid), 32'd1);
        chk("w2_bcd", 32'(out_bcd), 32'h9075);
        ack();
        chk_idle("w2_idle");

        send(P5); send(P6); send(PX);
        chk("e_valid", 32'(out_valid), 32'd1);
        chk("e_err", 32'(out_err), 32'd1);
        chk("e_bcd", 32'(out_bcd), 32'h0056);
        chk("e_inrdy", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("e_hold_inrdy", 32'(in_ready), 32'd0);
        chk("e_hold_err", 32'(out_err), 32'd1);
        ack();
        chk_idle("e_idle");

        send(P8); send(P8); send(P8); send(P8);
        @(negedge clk);
        in_valid = 1'b1;
        seg_in   = enc(P1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("s_bcd", 32'(out_bcd), 32'h8888);
            chk("s_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk) in_valid = 1'b0;
        ack();
        chk_idle("s_idle");

        send(P3); send(P1);
        chk("r_pre_bcd", 32'(out_bcd), 32'h31);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_idle("r_mid");
        @(negedge clk) reset = 1'b0;
        send(P2); send(P0); send(P2); send(P3);
        chk("r_valid", 32'(out_valid), 32'd1);
        chk("r_bcd", 32'(out_bcd), 32'h2023);
        ack();
        chk_idle("r_idle");

`ifdef SEG7_ACTIVE_LOW_EN
        send(~7'b0000001); send(~7'b1001111); send(~7'b0010010); send(~7'b0000110);
        chk("al_valid", 32'(out_valid), 32'd1);
        chk("al_bcd", 32'(out_bcd), 32'h0123);
        ack();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
